// File: rtl/fpu_issue_sequencer.sv
// fpu_issue_sequencer: handshake front/back-end around the handshake-less fpu core.
// Accepts one tagged operation at a time, holds the core operands stable for LAT
// edges, captures and classifies the core result, and queues it in a result FIFO.
module fpu_issue_sequencer #(
  parameter int DEPTH = 4,
  parameter int LAT   = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_opcode,
  input  logic [31:0]      fpu_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(LAT + 1);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [TAG_W-1:0]   tag_q;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               push;
  logic               pop;
  logic               accept;

  logic [31:0]        mem_result [DEPTH];
  logic [TAG_W-1:0]   mem_tag    [DEPTH];
  logic [3:0]         mem_flags  [DEPTH];

  // Result classification: {NaN, Inf, zero, subnormal}; at most one bit set.
  function automatic logic [3:0] classify(input logic [31:0] v);
    logic [7:0]  e;
    logic [22:0] f;
    logic        e_max;
    logic        e_min;
    logic        f_nz;
    e     = v[30:23];
    f     = v[22:0];
    e_max = (e == 8'hFF);
    e_min = (e == 8'h00);
    f_nz  = (f != 23'd0);
    classify = {e_max & f_nz, e_max & ~f_nz, e_min & ~f_nz, e_min & f_nz};
  endfunction

  // Only one operation is ever in flight, so IDLE plus a free slot reserves the
  // entry that the following CAPTURE will fill.
  assign in_ready  = (state == IDLE) && (count < FULL) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign push      = (state == CAPTURE) && !rst;
  assign pop       = out_valid && out_ready;

  assign out_result = mem_result[rd_ptr];
  assign out_tag    = mem_tag[rd_ptr];
  assign out_flags  = mem_flags[rd_ptr];

  // Issue FSM: load core operands on acceptance, count out the core latency, capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      fpu_a      <= 32'd0;
      fpu_b      <= 32'd0;
      fpu_opcode <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            fpu_a      <= in_a;
            fpu_b      <= in_b;
            fpu_opcode <= in_op;
            cnt        <= CNT_W'(LAT);
            state      <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= CAPTURE;
        end
        CAPTURE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tag travels with the in-flight operation; it carries no control meaning.
  always_ff @(posedge clk) begin
    if (accept) tag_q <= in_tag;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: written at capture with the core result, tag and classification.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= fpu_o;
      mem_tag[wr_ptr]    <= tag_q;
      mem_flags[wr_ptr]  <= classify(fpu_o);
    end
  end

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Self-checking bench for fpu_issue_sequencer: stand-in fpu core with LAT-edge
// latency, a transaction-level reference model, directed and random traffic.
module tb_fpu_issue_sequencer;

  localparam int DEPTH = 4;
  localparam int LAT   = 1;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic [1:0]       fpu_opcode;
  logic [31:0]      fpu_o;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;

  int n_checks = 0;
  int n_errors = 0;

  fpu_issue_sequencer #(.DEPTH(DEPTH), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_o(fpu_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  // Stand-in core arithmetic: exact for the known vectors, a deterministic scramble otherwise.
  function automatic logic [31:0] fcore(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    if (op == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op == 2'b00 && a == 32'h7FC00000 && b == 32'h3F800000) return 32'h7FC00000;
    if (op == 2'b11 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    case (op)
      2'b00:   return a ^ b;
      2'b01:   return a ^ b ^ 32'h80000000;
      2'b10:   return a + b;
      default: return (a == 32'd0 || b == 32'd0) ? 32'd0 : (a ^ b ^ 32'd1);
    endcase
  endfunction

  // Core with LAT edges from operand change to valid output.
  logic [31:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = 32'd0;
  always @(posedge clk) begin
    pipe[0] <= fcore(fpu_a, fpu_b, fpu_opcode);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign fpu_o = pipe[LAT-1];

  function automatic logic [3:0] ref_flags(input logic [31:0] v);
    int unsigned e;
    int unsigned f;
    e = (v >> 23) % 256;
    f = v % (1 << 23);
    if (e == 255) return (f != 0) ? 4'd8 : 4'd4;
    if (e == 0)   return (f != 0) ? 4'd1 : 4'd2;
    return 4'd0;
  endfunction

  typedef struct {
    logic [31:0]      r;
    logic [TAG_W-1:0] t;
    logic [3:0]       f;
    int               cap;
  } ent_t;

  ent_t        q[$];
  int          now = 0;
  int          last_acc = -100;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd0;
  logic [1:0]  m_op = 2'b00;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, now);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model and clock.
  task automatic step(input logic r, input logic iv, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [TAG_W-1:0] tg, input logic ordy,
                      output logic acc);
    logic exp_rdy;
    logic exp_ov;
    ent_t e;
    rst = r; in_valid = iv; in_a = a; in_b = b; in_op = op; in_tag = tg; out_ready = ordy;
    #1;
    exp_rdy = !r && !(now >= last_acc && now <= last_acc + LAT) && (q.size() < DEPTH);
    exp_ov  = (q.size() > 0) && (q[0].cap <= now);
    check_val("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    check_val("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    if (exp_ov && out_valid) begin
      check_val("out_result", out_result, q[0].r);
      check_val("out_tag", {28'd0, out_tag}, {28'd0, q[0].t});
      check_val("out_flags", {28'd0, out_flags}, {28'd0, q[0].f});
    end
    check_val("fpu_a", fpu_a, m_a);
    check_val("fpu_b", fpu_b, m_b);
    check_val("fpu_opcode", {30'd0, fpu_opcode}, {30'd0, m_op});
    acc = iv && exp_rdy;
    if (r) begin
      q.delete();
      m_a = 32'd0; m_b = 32'd0; m_op = 2'b00;
      last_acc = -100;
    end else begin
      if (exp_ov && ordy) void'(q.pop_front());
      if (acc) begin
        m_a = a; m_b = b; m_op = op;
        last_acc = now + 1;
        e.r = fcore(a, b, op);
        e.t = tg;
        e.f = ref_flags(e.r);
        e.cap = now + 1 + LAT + 1;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [TAG_W-1:0] tg, input logic ordy);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 60 && !acc; k++) step(1'b0, 1'b1, a, b, op, tg, ordy, acc);
    if (!acc) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got no acceptance expected acceptance within 60 cycles");
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, '0, ordy, acc);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h7F800000;
      1: return 32'h7FC00000;
      2: return 32'h00000001;
      3: return 32'h00000000;
      4: return 32'h80000000;
      5: return 32'h3F800000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic acc;
    int   cap_b;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    step(1'b1, 1'b0, 32'd0, 32'd0, 2'b00, '0, 1'b0, acc);

    // single ADD, then drain
    send(32'h3F800000, 32'h40000000, 2'b00, 4'h5, 1'b0);
    idle(4, 1'b0);
    idle(2, 1'b1);

    // back-to-back MUL and MUL by zero with the consumer always ready
    send(32'h40000000, 32'h40400000, 2'b11, 4'h1, 1'b1);
    send(32'h3F800000, 32'h00000000, 2'b11, 4'h2, 1'b1);
    idle(4, 1'b1);

    // NaN classification
    send(32'h7FC00000, 32'h3F800000, 2'b00, 4'h9, 1'b1);
    idle(4, 1'b1);

    // backpressure: four fill the FIFO, the fifth waits for a pop
    for (int i = 0; i < 4; i++) send(32'h3F800000, 32'h40000000 + i, 2'b00, 4'(i + 3), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'h11111111, 32'h0, 2'b10, 4'hE, 1'b0, acc);
    send(32'h11111111, 32'h0, 2'b10, 4'hE, 1'b1);
    idle(10, 1'b1);

    // push and pop on the same edge with one entry held
    send(32'h12345678, 32'h0, 2'b01, 4'hA, 1'b0);
    idle(3, 1'b0);
    send(32'h0F0F0F0F, 32'h00FF00FF, 2'b10, 4'hB, 1'b0);
    cap_b = now + LAT + 1;
    while (now + 1 <= cap_b) step(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, '0, (now + 1 == cap_b), acc);
    idle(2, 1'b0);
    idle(3, 1'b1);

    // reset while the operation is in flight
    send(32'h40000000, 32'h40400000, 2'b11, 4'h7, 1'b1);
    step(1'b1, 1'b0, 32'd0, 32'd0, 2'b00, '0, 1'b1, acc);
    idle(6, 1'b1);

    // random traffic with bursty consumer stalls
    for (int i = 0; i < 1500; i++) begin
      logic ordy;
      ordy = ((i / 37) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 299) == 0), $urandom_range(0, 1), pick(),
           ($urandom_range(0, 2) == 0) ? 32'd0 : pick(), 2'($urandom_range(0, 3)),
           4'($urandom), ordy, acc);
    end
    idle(3 * DEPTH + 10, 1'b1);
    check_val("drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
